// File: rtl/pcpi_issue_seq.sv
// pcpi_issue_seq: stand-alone PCPI initiator. Takes (insn, rs1, rs2) commands
// on a valid/ready stream, runs one PCPI transaction per command with
// picorv32-style timeout handling, and returns rd/wr/status on a response stream.
`timescale 1ns/1ps

module pcpi_issue_seq #(
  parameter int TIMEOUT  = 16,  // ISSUE cycles without pcpi_wait before abort, >= 1
  parameter int MAX_WAIT = 0    // absolute ISSUE-cycle cap, 0 = unlimited
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_wr,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT);
  localparam logic [WW-1:0] W_LAST = (MAX_WAIT == 0) ? '0 : WW'(MAX_WAIT - 1);

  localparam logic [1:0] ST_OK         = 2'b00;
  localparam logic [1:0] ST_TIMEOUT    = 2'b01;
  localparam logic [1:0] ST_WAIT_ABORT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   tcnt;
  logic [TW-1:0]   tcnt_next;
  logic [WW-1:0]   wcnt;
  logic            fin;
  logic [1:0]      fin_status;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state, handshake outputs and ISSUE-phase priority decode.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    pcpi_valid = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    fin        = 1'b0;
    fin_status = ST_OK;
    tcnt_next  = tcnt;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        pcpi_valid = 1'b1;
        // ready beats both aborts; wait only reloads the idle-timeout counter
        if (pcpi_ready) begin
          fin        = 1'b1;
          fin_status = ST_OK;
        end else if ((MAX_WAIT != 0) && (wcnt == W_LAST)) begin
          fin        = 1'b1;
          fin_status = ST_WAIT_ABORT;
        end else if (pcpi_wait) begin
          tcnt_next = T_LOAD;
        end else if (tcnt == TW'(1)) begin
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end else begin
          tcnt_next = tcnt - TW'(1);
        end
        if (fin) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, timeout counters, response capture and statistics.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      tcnt       <= '0;
      wcnt       <= '0;
      rsp_rd     <= '0;
      rsp_wr     <= 1'b0;
      rsp_status <= ST_OK;
      cnt_ok     <= '0;
      cnt_err    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            pcpi_insn <= cmd_insn;
            pcpi_rs1  <= cmd_rs1;
            pcpi_rs2  <= cmd_rs2;
            tcnt      <= T_LOAD;
            wcnt      <= '0;
          end
        end
        S_ISSUE: begin
          tcnt <= tcnt_next;
          wcnt <= wcnt + WW'(1);
          if (fin) begin
            // aborts report no write and a zero result
            rsp_wr     <= (fin_status == ST_OK) && pcpi_wr;
            rsp_rd     <= ((fin_status == ST_OK) && pcpi_wr) ? pcpi_rd : '0;
            rsp_status <= fin_status;
          end
        end
        S_RESP: begin
          // pcpi_ready/pcpi_wr are deliberately ignored here (stale responders)
          if (rsp_ready) begin
            if (rsp_status == ST_OK) begin
              if (cnt_ok != 16'hFFFF) cnt_ok <= cnt_ok + 16'd1;
            end else begin
              if (cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
